// File: rtl/ysyx_23060332_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding,
// reset constants and the bus-timer width.
package ysyx_23060332_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_WB         = 3'd5,
    ST_HALT       = 3'd6,
    ST_ERR        = 3'd7
  } state_e;

  // addi x0, x0, 0 -- what IDU sees before the first fetch completes
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // Wide enough for any timeout up to 2^16-1 cycles
  localparam int TIMER_W = 16;

  // States in which a bus handshake is outstanding and the timer runs
  function automatic logic isBusState(input state_e s);
    return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
           (s == ST_MEM_REQ)   || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_23060332_mc_ctrl_bus_timer.sv
// Cycle counter guarding bus handshakes. Counts while enabled, is cleared
// whenever the sequencer changes state, and flags the last allowed cycle.
module ysyx_23060332_mc_ctrl_bus_timer
  import ysyx_23060332_mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST_CYCLE = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear on state change, otherwise advance while waiting
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == LAST_CYCLE);

endmodule

// File: rtl/ysyx_23060332_mc_ctrl.sv
// Multi-cycle sequencer: walks each instruction through fetch, execute,
// optional load/store and writeback over valid/ready buses. Owns the PC,
// the held instruction and the retired-instruction counter.
module ysyx_23060332_mc_ctrl
  import ysyx_23060332_mc_ctrl_pkg::*;
#(
  parameter int                 XLEN     = 64,
  parameter logic [XLEN-1:0]    RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned        TIMEOUT  = 255,
  parameter int                 CNT_W    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             if_req_valid_o,
  input  logic             if_req_ready_i,
  output logic [XLEN-1:0]  if_req_addr_o,
  input  logic             if_resp_valid_i,
  input  logic [31:0]      if_resp_data_i,
  input  logic             if_resp_err_i,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  inst_addr_o,
  input  logic             mem_op_i,
  input  logic             jump_en_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic             halt_req_i,
  output logic             ls_req_valid_o,
  input  logic             ls_req_ready_i,
  input  logic             ls_resp_valid_i,
  input  logic             ls_resp_err_i,
  output logic             reg_wen_gate_o,
  output logic             halted_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic timerClear;
  logic timerEnable;
  logic timerExpire;
  logic jumpMisaligned;

  assign jumpMisaligned = jump_en_i && (jump_addr_i[1:0] != 2'b00);
  assign timerClear     = (state_d != state_q);
  assign timerEnable    = isBusState(state_q);

  ysyx_23060332_mc_ctrl_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timerClear),
    .enable_i (timerEnable),
    .expire_o (timerExpire)
  );

  // Next-state logic; a handshake in the timer's last cycle takes priority
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    unique case (state_q)
      ST_FETCH_REQ: begin
        if (if_req_ready_i) begin
          state_d = ST_FETCH_WAIT;
        end else if (timerExpire) begin
          state_d = ST_ERR;
        end
      end
      ST_FETCH_WAIT: begin
        if (if_resp_valid_i) begin
          inst_d  = if_resp_data_i;
          state_d = if_resp_err_i ? ST_ERR : ST_EXEC;
        end else if (timerExpire) begin
          state_d = ST_ERR;
        end
      end
      ST_EXEC: begin
        if (halt_req_i) begin
          instret_d = instret_q + CNT_W'(1);
          state_d   = ST_HALT;
        end else if (jumpMisaligned) begin
          state_d = ST_ERR;
        end else if (mem_op_i) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        if (ls_req_ready_i) begin
          state_d = ST_MEM_WAIT;
        end else if (timerExpire) begin
          state_d = ST_ERR;
        end
      end
      ST_MEM_WAIT: begin
        if (ls_resp_valid_i) begin
          state_d = ls_resp_err_i ? ST_ERR : ST_WB;
        end else if (timerExpire) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        pc_d      = jump_en_i ? jump_addr_i : pc_q + XLEN'(4);
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_FETCH_REQ;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Sequencer, PC, instruction and retire-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  // Requests are masked by reset so an asserted reset drops them immediately
  assign if_req_valid_o = (state_q == ST_FETCH_REQ) && !rst_i;
  assign ls_req_valid_o = (state_q == ST_MEM_REQ)   && !rst_i;
  assign reg_wen_gate_o = (state_q == ST_WB)        && !rst_i;
  assign halted_o       = (state_q == ST_HALT)      && !rst_i;
  assign bus_err_o      = (state_q == ST_ERR)       && !rst_i;
  assign if_req_addr_o  = pc_q;
  assign inst_addr_o    = pc_q;
  assign inst_o         = inst_q;
  assign instret_o      = instret_q;

endmodule

// File: tb/tb_ysyx_23060332_mc_ctrl.sv
// Directed testbench for the multi-cycle sequencer, with simple IFU/LSU
// responders whose ready and response latencies are set per scenario.
module tb_ysyx_23060332_mc_ctrl;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifReqValid, ifReqReady, ifRespValid, ifRespErr;
  logic [63:0] ifReqAddr, instAddr, jumpAddr, instret;
  logic [31:0] ifRespData, inst;
  logic        memOp, jumpEn, haltReq;
  logic        lsReqValid, lsReqReady, lsRespValid, lsRespErr;
  logic        regWenGate, halted, busErr;

  int checks   = 0;
  int failures = 0;

  int ifReadyDelay = 0, ifRespDelay = 0, lsReadyDelay = 0, lsRespDelay = 0;
  int ifReqCnt = 0, ifRespCnt = 0, lsReqCnt = 0, lsRespCnt = 0;
  logic ifPend = 1'b0, lsPend = 1'b0;
  logic [31:0] ifData = NOP;

  ysyx_23060332_mc_ctrl #(
    .XLEN    (64),
    .RESET_PC(RST_PC),
    .TIMEOUT (8),
    .CNT_W   (64)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_req_valid_o (ifReqValid),
    .if_req_ready_i (ifReqReady),
    .if_req_addr_o  (ifReqAddr),
    .if_resp_valid_i(ifRespValid),
    .if_resp_data_i (ifRespData),
    .if_resp_err_i  (ifRespErr),
    .inst_o         (inst),
    .inst_addr_o    (instAddr),
    .mem_op_i       (memOp),
    .jump_en_i      (jumpEn),
    .jump_addr_i    (jumpAddr),
    .halt_req_i     (haltReq),
    .ls_req_valid_o (lsReqValid),
    .ls_req_ready_i (lsReqReady),
    .ls_resp_valid_i(lsRespValid),
    .ls_resp_err_i  (lsRespErr),
    .reg_wen_gate_o (regWenGate),
    .halted_o       (halted),
    .bus_err_o      (busErr),
    .instret_o      (instret)
  );

  always #5 clk = ~clk;

  // Bus slaves: accept after ready delay, answer after response delay
  initial begin
    ifReqReady = 1'b0; ifRespValid = 1'b0; ifRespErr = 1'b0; ifRespData = NOP;
    lsReqReady = 1'b0; lsRespValid = 1'b0; lsRespErr = 1'b0;
    forever begin
      @(negedge clk);
      ifReqReady = 1'b0; ifRespValid = 1'b0; ifRespErr = 1'b0;
      lsReqReady = 1'b0; lsRespValid = 1'b0; lsRespErr = 1'b0;
      ifRespData = ifData;
      if (rst) begin
        ifReqCnt = 0; ifRespCnt = 0; ifPend = 1'b0;
        lsReqCnt = 0; lsRespCnt = 0; lsPend = 1'b0;
      end else begin
        if (ifReqValid) begin
          if (ifReqCnt == ifReadyDelay) begin
            ifReqReady = 1'b1; ifReqCnt = 0; ifPend = 1'b1; ifRespCnt = 0;
          end else begin
            ifReqCnt++;
          end
        end else if (ifPend) begin
          if (ifRespCnt == ifRespDelay) begin
            ifRespValid = 1'b1; ifPend = 1'b0;
          end else begin
            ifRespCnt++;
          end
        end
        if (lsReqValid) begin
          if (lsReqCnt == lsReadyDelay) begin
            lsReqReady = 1'b1; lsReqCnt = 0; lsPend = 1'b1; lsRespCnt = 0;
          end else begin
            lsReqCnt++;
          end
        end else if (lsPend) begin
          if (lsRespCnt == lsRespDelay) begin
            lsRespValid = 1'b1; lsPend = 1'b0;
          end else begin
            lsRespCnt++;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Configure EXU/IDU inputs and slave latencies, reset, stop at first fetch cycle
  task automatic applyStimulus(input logic mo, input logic je, input logic [63:0] ja,
                               input logic hr, input int ifRd, input int ifRsp,
                               input int lsRd, input int lsRsp, input logic [31:0] data);
    rst = 1'b1;
    memOp = mo; jumpEn = je; jumpAddr = ja; haltReq = hr;
    ifReadyDelay = ifRd; ifRespDelay = ifRsp;
    lsReadyDelay = lsRd; lsRespDelay = lsRsp;
    ifData = data;
    step(2);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    memOp = 1'b0; jumpEn = 1'b0; jumpAddr = '0; haltReq = 1'b0;

    // Reset state
    step(2);
    checkOutput("rst_if_valid", {63'd0, ifReqValid}, 64'd0);
    checkOutput("rst_ls_valid", {63'd0, lsReqValid}, 64'd0);
    checkOutput("rst_addr", ifReqAddr, RST_PC);
    checkOutput("rst_inst_addr", instAddr, RST_PC);
    checkOutput("rst_inst", {32'd0, inst}, {32'd0, NOP});
    checkOutput("rst_instret", instret, 64'd0);
    checkOutput("rst_flags", {61'd0, regWenGate, halted, busErr}, 64'd0);

    // 1: ALU stream with zero-wait IFU
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 0, 0, 0, 0, 32'h0010_0093);
    checkOutput("s1_valid0", {63'd0, ifReqValid}, 64'd1);
    checkOutput("s1_addr0", ifReqAddr, RST_PC);
    step(3);
    checkOutput("s1_wen", {63'd0, regWenGate}, 64'd1);
    step(1);
    checkOutput("s1_addr1", ifReqAddr, RST_PC + 64'd4);
    checkOutput("s1_instret1", instret, 64'd1);
    step(4);
    checkOutput("s1_addr2", ifReqAddr, RST_PC + 64'd8);
    step(4);
    checkOutput("s1_addr3", ifReqAddr, RST_PC + 64'd12);
    checkOutput("s1_instret3", instret, 64'd3);
    checkOutput("s1_inst", {32'd0, inst}, 64'h0010_0093);

    // 2: slow IFU, ready after 3 cycles, response 2 cycles later
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 3, 2, 0, 0, 32'h0050_0113);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1);
      if (ifReqValid) cnt++;
    end
    checkOutput("s2_valid_cycles", 64'(cnt), 64'd4);
    checkOutput("s2_inst_before", {32'd0, inst}, {32'd0, NOP});
    step(1);
    checkOutput("s2_inst_latched", {32'd0, inst}, 64'h0050_0113);
    checkOutput("s2_exec_no_wen", {63'd0, regWenGate}, 64'd0);
    step(1);
    checkOutput("s2_wb_wen", {63'd0, regWenGate}, 64'd1);
    checkOutput("s2_inst_held", {32'd0, inst}, 64'h0050_0113);

    // 3a: aligned jump redirects the next fetch
    applyStimulus(1'b0, 1'b1, 64'h8000_0100, 1'b0, 0, 0, 0, 0, 32'h1000_006f);
    step(4);
    checkOutput("s3_jump_valid", {63'd0, ifReqValid}, 64'd1);
    checkOutput("s3_jump_addr", ifReqAddr, 64'h8000_0100);

    // 3b: misaligned jump target is a bus error, pc frozen
    applyStimulus(1'b0, 1'b1, 64'h8000_0102, 1'b0, 0, 0, 0, 0, 32'h1020_006f);
    step(3);
    checkOutput("s3_mis_err", {63'd0, busErr}, 64'd1);
    checkOutput("s3_mis_pc", instAddr, RST_PC);
    checkOutput("s3_mis_instret", instret, 64'd0);
    step(3);
    checkOutput("s3_err_sticky", {63'd0, busErr}, 64'd1);
    checkOutput("s3_err_no_req", {62'd0, ifReqValid, lsReqValid}, 64'd0);
    checkOutput("s3_err_addr", ifReqAddr, RST_PC);

    // 4: load with a 5-cycle LSU response wait
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 0, 0, 0, 5, 32'h0000_3183);
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step(1);
      if (regWenGate) cnt++;
      if (i == 3) checkOutput("s4_ls_valid", {63'd0, lsReqValid}, 64'd1);
      if (i == 9) checkOutput("s4_no_wen_at_resp", {63'd0, regWenGate}, 64'd0);
    end
    checkOutput("s4_wen_pulses", 64'(cnt), 64'd1);
    checkOutput("s4_wen_after_resp", {63'd0, regWenGate}, 64'd1);
    step(1);
    checkOutput("s4_next_addr", ifReqAddr, RST_PC + 64'd4);
    checkOutput("s4_instret", instret, 64'd1);

    // 5a: IFU never ready, timeout after 8 cycles
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 100, 0, 0, 0, NOP);
    step(7);
    checkOutput("s5_no_err_yet", {63'd0, busErr}, 64'd0);
    step(1);
    checkOutput("s5_timeout_err", {63'd0, busErr}, 64'd1);
    checkOutput("s5_timeout_no_req", {63'd0, ifReqValid}, 64'd0);

    // 5b: ready arrives in the 8th cycle, handshake wins
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 7, 0, 0, 0, NOP);
    step(8);
    checkOutput("s5_edge_no_err", {63'd0, busErr}, 64'd0);
    step(3);
    checkOutput("s5_edge_next_valid", {63'd0, ifReqValid}, 64'd1);
    checkOutput("s5_edge_next_addr", ifReqAddr, RST_PC + 64'd4);
    checkOutput("s5_edge_still_ok", {63'd0, busErr}, 64'd0);

    // 6a: ebreak halts and counts itself
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0, 0, 32'h0010_0073);
    step(3);
    checkOutput("s6_halted", {63'd0, halted}, 64'd1);
    checkOutput("s6_instret", instret, 64'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (ifReqValid || lsReqValid) cnt++;
    end
    checkOutput("s6_no_requests", 64'(cnt), 64'd0);
    checkOutput("s6_halt_sticky", {63'd0, halted}, 64'd1);

    // 6b: reset asserted in the middle of MEM_WAIT of the second load
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 0, 0, 0, 5, 32'h0000_3183);
    step(15);
    checkOutput("s6_pre_rst_addr", instAddr, RST_PC + 64'd4);
    checkOutput("s6_pre_rst_instret", instret, 64'd1);
    step(1);
    rst = 1'b1;
    #1;
    checkOutput("s6_rst_addr", ifReqAddr, RST_PC);
    checkOutput("s6_rst_no_req", {62'd0, ifReqValid, lsReqValid}, 64'd0);
    checkOutput("s6_rst_instret", instret, 64'd0);
    step(2);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("s6_refetch_valid", {63'd0, ifReqValid}, 64'd1);
    checkOutput("s6_refetch_addr", ifReqAddr, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
